// File: rtl/usr_pkg.sv
// Package: usr_pkg
// Shared types and helpers for the universal shift register.
//   usr_mode_e   : 3-bit operation select encoding
//   usr_is_shift : 1 when a mode moves data by one bit position. These are
//                  the modes the word counter tracks.
// Optional macro: USR_ROTATE_EN adds ROL/ROR to the set of counted shifts.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'b000,
        SHL   = 3'b001,
        SHR   = 3'b010,
        LOAD  = 3'b011,
        ROL   = 3'b100,
        ROR   = 3'b101,
        CLEAR = 3'b110,
        RSVD  = 3'b111
    } usr_mode_e;

    function automatic logic usr_is_shift(input usr_mode_e mode);
`ifdef USR_ROTATE_EN
        return (mode == SHL) || (mode == SHR) || (mode == ROL) || (mode == ROR);
`else
        return (mode == SHL) || (mode == SHR);
`endif
    endfunction

endpackage

// File: rtl/usr_word_counter.sv
// Module: usr_word_counter
// Counts single-bit shifts modulo WIDTH. It pulses wrap_pulse for one cycle
// after the WIDTH-th shift of a word.
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   step       in  a counted shift happens this cycle
//   clear      in  restart the word (load/clear); takes priority over step
//   cnt        out shifts completed in the current word
//   wrap_pulse out registered one-cycle pulse on word completion
module usr_word_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          wrap_pulse
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge and the simulation cannot race.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wrap_pulse <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            wrap_pulse <= 1'b0;
        end else if (step) begin
            if (cnt == CNT_MAX) begin
                cnt        <= '0;
                wrap_pulse <= 1'b1;
            end else begin
                cnt        <= cnt + 1'b1;
                wrap_pulse <= 1'b0;
            end
        end else begin
            // Hold the count. The pulse drops, so it can only last one cycle.
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Module: universal_shift_register
// Parametrised universal shift register. It supports left/right shift,
// parallel load, clear and hold, with serial I/O in both directions. A word
// counter flags each completed WIDTH-bit word for serial<->parallel conversion.
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset (priority over all)
//   en         in  operation enable; 0 holds q and the count
//   mode       in  operation select (usr_mode_e encoding)
//   sin_l      in  serial in, enters q[0] on a left shift
//   sin_r      in  serial in, enters q[WIDTH-1] on a right shift
//   pin        in  parallel load data
//   q          out register contents
//   sout_l     out q[WIDTH-1]
//   sout_r     out q[0]
//   shift_cnt  out shifts since last load/clear/wrap
//   word_done  out one-cycle pulse after the WIDTH-th shift
// Optional macro: USR_ROTATE_EN enables ROL/ROR. When it is undefined, those
// two modes act as HOLD and no rotate logic is built.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    usr_mode_e        op;
    logic [WIDTH-1:0] q_next;
    logic             cnt_step;
    logic             cnt_clear;

    assign op = usr_mode_e'(mode);

    // NOTE: q_next gets a default before the case, so an unlisted mode can
    // never leave it unassigned and infer a latch.
    always_comb begin
        q_next = q;
        if (en) begin
            case (op)
                SHL:     q_next = {q[WIDTH-2:0], sin_l};
                SHR:     q_next = {sin_r, q[WIDTH-1:1]};
                LOAD:    q_next = pin;
`ifdef USR_ROTATE_EN
                ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                ROR:     q_next = {q[0], q[WIDTH-1:1]};
`endif
                CLEAR:   q_next = RESET_VAL;
                default: q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

    // A load or clear restarts the word. Because clear has priority inside the
    // counter, a load in the wrap cycle suppresses the pulse.
    assign cnt_step  = en && usr_is_shift(op);
    assign cnt_clear = en && ((op == LOAD) || (op == CLEAR));

    usr_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .clk        (clk),
        .rst        (rst),
        .step       (cnt_step),
        .clear      (cnt_clear),
        .cnt        (shift_cnt),
        .wrap_pulse (word_done)
    );

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench: tb_universal_shift_register
// Directed tests for universal_shift_register with WIDTH=8. The rotate
// expectations follow USR_ROTATE_EN, the same macro the design is built with.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] pin = 8'h00;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [2:0] shift_cnt;
    logic       word_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    universal_shift_register #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .pin       (pin),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    // Apply one operation, let one rising edge pass, and return 1 ns later so
    // outputs are sampled away from the edge.
    task automatic op(input logic e, input logic [2:0] m, input logic sl,
                      input logic sr, input logic [7:0] p);
        en = e; mode = m; sin_l = sl; sin_r = sr; pin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op(1'b1, 3'b001, 1'b1, 1'b0, 8'hFF);
        op(1'b1, 3'b001, 1'b1, 1'b0, 8'hFF);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want %h", q, 8'h00); end
        checks++; if (shift_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", shift_cnt); end
        checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_wd got %b want 0", word_done); end
        rst = 1'b0;
    endtask

    task automatic test_shl();
        logic [3:0] bits = 4'b1011;  // applied MSB first: 1,0,1,1
        logic [7:0] exp_q [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 3'b001, bits[3-i], 1'b0, 8'h00);
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shl_q[%0d] got %h want %h", i, q, exp_q[i]); end
        end
        checks++; if (shift_cnt !== 3'd4) begin errors++; $display("FAIL shl_cnt got %0d want 4", shift_cnt); end
        checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL shl_wd got %b want 0", word_done); end
    endtask

    task automatic test_shr_word();
        logic [7:0] exp_q;
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'hA5);
        checks++; if (q !== 8'hA5 || shift_cnt !== 3'd0) begin errors++; $display("FAIL load_a5 got q=%h cnt=%0d want q=a5 cnt=0", q, shift_cnt); end
        exp_q = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            op(1'b1, 3'b010, 1'b0, 1'b0, 8'h00);
            exp_q = exp_q >> 1;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL shr_q[%0d] got %h want %h", k, q, exp_q); end
            checks++; if (sout_r !== exp_q[0]) begin errors++; $display("FAIL shr_sout_r[%0d] got %b want %b", k, sout_r, exp_q[0]); end
            checks++; if (word_done !== (k == 8)) begin errors++; $display("FAIL shr_wd[%0d] got %b want %b", k, word_done, (k == 8)); end
            checks++; if (shift_cnt !== 3'(k % 8)) begin errors++; $display("FAIL shr_cnt[%0d] got %0d want %0d", k, shift_cnt, k % 8); end
        end
        op(1'b1, 3'b000, 1'b0, 1'b0, 8'h00);
        checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL shr_wd_after got %b want 0", word_done); end
    endtask

    task automatic test_rotate();
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h81);
        op(1'b1, 3'b100, 1'b0, 1'b0, 8'h00);
`ifdef USR_ROTATE_EN
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rol_q got %h want 03", q); end
        checks++; if (sout_l !== 1'b0 || sout_r !== 1'b1) begin errors++; $display("FAIL rol_sout got l=%b r=%b want l=0 r=1", sout_l, sout_r); end
        checks++; if (shift_cnt !== 3'd1) begin errors++; $display("FAIL rol_cnt got %0d want 1", shift_cnt); end
        op(1'b1, 3'b101, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h81 || shift_cnt !== 3'd2) begin errors++; $display("FAIL ror got q=%h cnt=%0d want q=81 cnt=2", q, shift_cnt); end
`else
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL rol_off_q got %h want 81", q); end
        checks++; if (shift_cnt !== 3'd0) begin errors++; $display("FAIL rol_off_cnt got %0d want 0", shift_cnt); end
        op(1'b1, 3'b101, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h81 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin errors++; $display("FAIL ror_off got q=%h cnt=%0d wd=%b want q=81 cnt=0 wd=0", q, shift_cnt, word_done); end
`endif
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_q;
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        checks++; if (shift_cnt !== 3'd3) begin errors++; $display("FAIL mid_pre_cnt got %0d want 3", shift_cnt); end
        rst = 1'b1;
        op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        checks++; if (q !== 8'h00 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin errors++; $display("FAIL mid_rst got q=%h cnt=%0d wd=%b want q=00 cnt=0 wd=0", q, shift_cnt, word_done); end
        exp_q = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
            exp_q = {exp_q[6:0], 1'b1};
            checks++; if (word_done !== (k == 8)) begin errors++; $display("FAIL mid_wd[%0d] got %b want %b", k, word_done, (k == 8)); end
            checks++; if (q !== exp_q) begin errors++; $display("FAIL mid_q[%0d] got %h want %h", k, q, exp_q); end
        end
    endtask

    task automatic test_hold();
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h3C);
        op(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
        op(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'hF0 || shift_cnt !== 3'd2) begin errors++; $display("FAIL hold_pre got q=%h cnt=%0d want q=f0 cnt=2", q, shift_cnt); end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 3'b001, i[0], 1'b1, 8'hFF);
            checks++; if (q !== 8'hF0 || shift_cnt !== 3'd2 || word_done !== 1'b0) begin errors++; $display("FAIL en0[%0d] got q=%h cnt=%0d wd=%b want q=f0 cnt=2 wd=0", i, q, shift_cnt, word_done); end
        end
        op(1'b1, 3'b111, 1'b1, 1'b1, 8'hFF);
        checks++; if (q !== 8'hF0 || shift_cnt !== 3'd2) begin errors++; $display("FAIL rsvd got q=%h cnt=%0d want q=f0 cnt=2", q, shift_cnt); end
        op(1'b1, 3'b000, 1'b1, 1'b1, 8'hFF);
        checks++; if (q !== 8'hF0 || shift_cnt !== 3'd2) begin errors++; $display("FAIL hold got q=%h cnt=%0d want q=f0 cnt=2", q, shift_cnt); end
        op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        checks++; if (q !== 8'hE1 || shift_cnt !== 3'd3) begin errors++; $display("FAIL hold_resume got q=%h cnt=%0d want q=e1 cnt=3", q, shift_cnt); end
    endtask

    task automatic test_wrap_cycle_clear();
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) op(1'b1, 3'b010, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h01 || shift_cnt !== 3'd7) begin errors++; $display("FAIL mixed got q=%h cnt=%0d want q=01 cnt=7", q, shift_cnt); end
        op(1'b1, 3'b110, 1'b0, 1'b0, 8'hFF);
        checks++; if (q !== 8'h00 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin errors++; $display("FAIL clear_wrap got q=%h cnt=%0d wd=%b want q=00 cnt=0 wd=0", q, shift_cnt, word_done); end
        for (int i = 0; i < 7; i++) op(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h55);
        checks++; if (q !== 8'h55 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin errors++; $display("FAIL load_wrap got q=%h cnt=%0d wd=%b want q=55 cnt=0 wd=0", q, shift_cnt, word_done); end
        op(1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
        checks++; if (q !== 8'hAA || shift_cnt !== 3'd1 || sout_l !== 1'b1) begin errors++; $display("FAIL shr_in got q=%h cnt=%0d sl=%b want q=aa cnt=1 sl=1", q, shift_cnt, sout_l); end
    endtask

    task automatic test_back_to_back();
        op(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            op(1'b1, 3'b001, k[0], 1'b0, 8'h00);
            checks++; if (word_done !== (k == 8 || k == 16)) begin errors++; $display("FAIL b2b_wd[%0d] got %b want %b", k, word_done, (k == 8 || k == 16)); end
        end
        checks++; if (q !== 8'hAA) begin errors++; $display("FAIL b2b_q got %h want aa", q); end
    endtask

    initial begin
        test_reset();
        test_shl();
        test_shr_word();
        test_rotate();
        test_reset_mid_word();
        test_hold();
        test_wrap_cycle_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
